// File: rtl/contador_param_if.sv
// Bus bundle for contador_param: event strobes, clear and read request in,
// read response and sticky overflow flags out.
interface contador_param_if #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 6,
    parameter int IDX_W  = 3
) ();
    logic [NUM_CH-1:0] push;
    logic              clr;
    logic              req;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  data;
    logic              valid;
    logic              err;
    logic [NUM_CH-1:0] overflow;

    modport master (
        output push, clr, req, idx,
        input  data, valid, err, overflow
    );

    modport slave (
        input  push, clr, req, idx,
        output data, valid, err, overflow
    );
endinterface

// File: rtl/contador_param.sv
// Multi-channel event counter with a registered one-cycle read port,
// selectable wrap/saturate behaviour, optional clear-on-read and sticky overflow flags.
module contador_param #(
    parameter int NUM_CH        = 5,
    parameter int CNT_W         = 6,
    parameter int IDX_W         = 3,
    parameter int SATURATE      = 0,
    parameter int CLEAR_ON_READ = 0
) (
    input logic            clk,
    input logic            reset_L,
    contador_param_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r     [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] ovf_r;
    logic [NUM_CH-1:0] ovf_nxt_s;
    logic [NUM_CH-1:0] rd_hit_s;
    logic [CNT_W-1:0]  rd_val_s;
    logic              idx_ok_s;
    logic [CNT_W-1:0]  data_r;
    logic [CNT_W-1:0]  data_nxt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic              err_r;
    logic              err_nxt_s;

    // Decode the requested channel; an index with no matching channel is out of range
    always_comb begin
        rd_hit_s = {NUM_CH{1'b0}};
        rd_val_s = CNT_ZERO;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bus.idx == IDX_W'(ch)) begin
                rd_hit_s[ch] = 1'b1;
                rd_val_s     = cnt_r[ch];
            end else begin
                rd_hit_s[ch] = 1'b0;
            end
        end
        idx_ok_s = |rd_hit_s;
    end

    // Per-channel next count: clear beats clear-on-read, which beats a plain push
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_nxt_s[ch] = cnt_r[ch];
            ovf_nxt_s[ch] = ovf_r[ch];
            if (bus.clr) begin
                cnt_nxt_s[ch] = CNT_ZERO;
                ovf_nxt_s[ch] = 1'b0;
            end else if ((CLEAR_ON_READ != 0) && bus.req && rd_hit_s[ch]) begin
                cnt_nxt_s[ch] = bus.push[ch] ? CNT_ONE : CNT_ZERO;
                ovf_nxt_s[ch] = 1'b0;
            end else if (bus.push[ch]) begin
                if (cnt_r[ch] == CNT_MAX) begin
                    ovf_nxt_s[ch] = 1'b1;
                    cnt_nxt_s[ch] = (SATURATE != 0) ? CNT_MAX : CNT_ZERO;
                end else begin
                    cnt_nxt_s[ch] = cnt_r[ch] + CNT_ONE;
                end
            end else begin
                cnt_nxt_s[ch] = cnt_r[ch];
                ovf_nxt_s[ch] = ovf_r[ch];
            end
        end
    end

    // Read FSM next state and registered read response; data holds when idle
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = data_r;
        valid_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (bus.req) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        if (bus.req) begin
            if (idx_ok_s) begin
                data_nxt_s  = rd_val_s;
                valid_nxt_s = 1'b1;
            end else begin
                data_nxt_s = CNT_ZERO;
                err_nxt_s  = 1'b1;
            end
        end else begin
            data_nxt_s = data_r;
        end
    end

    // FSM and read response registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= IDLE;
            data_r  <= CNT_ZERO;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Counter and overflow registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_r[ch] <= CNT_ZERO;
            end
            ovf_r <= {NUM_CH{1'b0}};
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_r[ch] <= cnt_nxt_s[ch];
            end
            ovf_r <= ovf_nxt_s;
        end
    end

    assign bus.data     = data_r;
    assign bus.valid    = valid_r;
    assign bus.err      = err_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_contador_param.sv
// Scoreboard bench: three contador_param variants (wrap, saturate, clear-on-read)
// driven by identical directed and random stimulus, checked against an arithmetic model.
module tb_contador_param;
    localparam int NUM_CH = 5;
    localparam int CNT_W  = 6;
    localparam int IDX_W  = 3;
    localparam int NI     = 3;
    localparam int MODV   = 2 ** CNT_W;

    logic clk = 1'b0;
    logic reset_L;
    logic [NUM_CH-1:0] push_s;
    logic clr_s, req_s;
    logic [IDX_W-1:0] idx_s;

    always #5 clk = ~clk;

    contador_param_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus0 ();
    contador_param_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus1 ();
    contador_param_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus2 ();

    assign bus0.push = push_s; assign bus0.clr = clr_s; assign bus0.req = req_s; assign bus0.idx = idx_s;
    assign bus1.push = push_s; assign bus1.clr = clr_s; assign bus1.req = req_s; assign bus1.idx = idx_s;
    assign bus2.push = push_s; assign bus2.clr = clr_s; assign bus2.req = req_s; assign bus2.idx = idx_s;

    contador_param #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SATURATE(0), .CLEAR_ON_READ(0))
        dut0 (.clk(clk), .reset_L(reset_L), .bus(bus0.slave));
    contador_param #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SATURATE(1), .CLEAR_ON_READ(0))
        dut1 (.clk(clk), .reset_L(reset_L), .bus(bus1.slave));
    contador_param #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SATURATE(0), .CLEAR_ON_READ(1))
        dut2 (.clk(clk), .reset_L(reset_L), .bus(bus2.slave));

    logic [CNT_W-1:0]  dat_s [NI];
    logic              val_s [NI];
    logic              err_s [NI];
    logic [NUM_CH-1:0] ovf_s [NI];
    assign dat_s[0] = bus0.data; assign val_s[0] = bus0.valid; assign err_s[0] = bus0.err; assign ovf_s[0] = bus0.overflow;
    assign dat_s[1] = bus1.data; assign val_s[1] = bus1.valid; assign err_s[1] = bus1.err; assign ovf_s[1] = bus1.overflow;
    assign dat_s[2] = bus2.data; assign val_s[2] = bus2.valid; assign err_s[2] = bus2.err; assign ovf_s[2] = bus2.overflow;

    typedef struct { int data; bit valid; bit err; } rd_t;
    typedef struct { int data; logic [NUM_CH-1:0] ovf; } st_t;

    int sat_p [NI] = '{0, 1, 0};
    int cor_p [NI] = '{0, 0, 1};
    int m_cnt [NI][NUM_CH];
    bit m_ovf [NI][NUM_CH];
    int m_data [NI];
    rd_t rdq [NI][$];
    st_t stq [NI][$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int j, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, j, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NI; j++) begin
            m_data[j] = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_cnt[j][ch] = 0;
                m_ovf[j][ch] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, queue the responses the next edge must produce, advance the model.
    task automatic cycle(input logic [NUM_CH-1:0] p, input logic c, input logic r, input logic [IDX_W-1:0] ix);
        rd_t e;
        st_t s;
        int v;
        push_s = p; clr_s = c; req_s = r; idx_s = ix;
        for (int j = 0; j < NI; j++) begin
            if (r) begin
                if (int'(ix) < NUM_CH) begin
                    e.data = m_cnt[j][ix]; e.valid = 1'b1; e.err = 1'b0;
                end else begin
                    e.data = 0; e.valid = 1'b0; e.err = 1'b1;
                end
                m_data[j] = e.data;
                rdq[j].push_back(e);
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (c) begin
                    m_cnt[j][ch] = 0;
                    m_ovf[j][ch] = 1'b0;
                end else if (cor_p[j] != 0 && r && int'(ix) == ch) begin
                    m_cnt[j][ch] = p[ch] ? 1 : 0;
                    m_ovf[j][ch] = 1'b0;
                end else if (p[ch]) begin
                    v = m_cnt[j][ch] + 1;
                    if (v >= MODV) begin
                        m_ovf[j][ch] = 1'b1;
                        v = (sat_p[j] != 0) ? MODV - 1 : v % MODV;
                    end
                    m_cnt[j][ch] = v;
                end
            end
            s.data = m_data[j];
            for (int ch = 0; ch < NUM_CH; ch++) s.ovf[ch] = m_ovf[j][ch];
            stq[j].push_back(s);
        end
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset pulse between edges while a read response is on the outputs.
    task automatic mid_reset();
        #1 reset_L = 1'b0;
        #1;
        for (int j = 0; j < NI; j++) begin
            chk("rst_valid", j, 32'(val_s[j]), 32'd0);
            chk("rst_data", j, 32'(dat_s[j]), 32'd0);
            chk("rst_ovf", j, 32'(ovf_s[j]), 32'd0);
        end
        push_s = '0; clr_s = 1'b0; req_s = 1'b0; idx_s = '0;
        model_reset();
        #2 reset_L = 1'b1;
    endtask

    // Monitor: pop a read response whenever a DUT presents one, check status every edge
    initial begin
        rd_t e;
        st_t s;
        forever begin
            @(posedge clk);
            #1;
            if (reset_L) begin
                for (int j = 0; j < NI; j++) begin
                    if (stq[j].size() > 0) begin
                        s = stq[j].pop_front();
                        chk("data_hold", j, 32'(dat_s[j]), 32'(s.data));
                        chk("overflow", j, 32'(ovf_s[j]), 32'(s.ovf));
                    end
                    if (val_s[j] || err_s[j]) begin
                        if (rdq[j].size() == 0) begin
                            chk("unexpected_resp", j, 32'(val_s[j]), 32'd0);
                        end else begin
                            e = rdq[j].pop_front();
                            chk("rd_data", j, 32'(dat_s[j]), 32'(e.data));
                            chk("rd_valid", j, 32'(val_s[j]), 32'(e.valid));
                            chk("rd_err", j, 32'(err_s[j]), 32'(e.err));
                        end
                    end
                    if (rdq[j].size() != 0) begin
                        chk("missing_resp", j, 32'(rdq[j].size()), 32'd0);
                        rdq[j].delete();
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_L = 1'b0;
        push_s = '0; clr_s = 1'b0; req_s = 1'b0; idx_s = '0;
        model_reset();
        #3;
        for (int j = 0; j < NI; j++) begin
            chk("reset_data", j, 32'(dat_s[j]), 32'd0);
            chk("reset_valid", j, 32'(val_s[j]), 32'd0);
            chk("reset_err", j, 32'(err_s[j]), 32'd0);
            chk("reset_ovf", j, 32'(ovf_s[j]), 32'd0);
        end
        @(posedge clk);
        #2 reset_L = 1'b1;

        // Three pushes on channel 0, then read it
        for (int i = 0; i < 3; i++) cycle(5'b00001, 1'b0, 1'b0, 3'd0);
        cycle(5'b00000, 1'b0, 1'b1, 3'd0);
        cycle(5'b00000, 1'b0, 1'b0, 3'd0);

        // Ten pushes on channels 0..2, then back-to-back reads of 0..3
        cycle(5'b00000, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 10; i++) cycle(5'b00111, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) cycle(5'b00000, 1'b0, 1'b1, 3'(i));
        cycle(5'b00000, 1'b0, 1'b0, 3'd0);

        // 65 pushes on channel 1: wraps to 1 or saturates at 63
        cycle(5'b00000, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 65; i++) cycle(5'b00010, 1'b0, 1'b0, 3'd0);
        cycle(5'b00000, 1'b0, 1'b1, 3'd1);
        cycle(5'b00000, 1'b0, 1'b0, 3'd0);

        // Read channel 2 at 4 while it is pushed, then read it again
        cycle(5'b00000, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) cycle(5'b00100, 1'b0, 1'b0, 3'd0);
        cycle(5'b00100, 1'b0, 1'b1, 3'd2);
        cycle(5'b00000, 1'b0, 1'b1, 3'd2);
        cycle(5'b00000, 1'b0, 1'b0, 3'd0);

        // Out-of-range read, then clear together with pushes on every channel
        cycle(5'b00000, 1'b0, 1'b1, 3'd6);
        cycle(5'b11111, 1'b1, 1'b1, 3'd1);
        for (int i = 0; i < NUM_CH; i++) cycle(5'b00000, 1'b0, 1'b1, 3'(i));

        // Reset pulsed mid-read, then confirm counters restart from zero
        for (int i = 0; i < 3; i++) cycle(5'b01010, 1'b0, 1'b0, 3'd0);
        cycle(5'b00000, 1'b0, 1'b1, 3'd1);
        mid_reset();
        cycle(5'b00000, 1'b0, 1'b1, 3'd1);
        cycle(5'b00000, 1'b0, 1'b1, 3'd3);

        // Random traffic with rare clears so overflows get exercised
        for (int i = 0; i < 500; i++) begin
            cycle(NUM_CH'($urandom), ($urandom_range(199) == 0), 1'($urandom_range(1)), IDX_W'($urandom_range(7)));
        end
        for (int i = 0; i < NUM_CH; i++) cycle(5'b00000, 1'b0, 1'b1, 3'(i));
        cycle(5'b00000, 1'b0, 1'b0, 3'd0);
        cycle(5'b00000, 1'b0, 1'b0, 3'd0);

        for (int j = 0; j < NI; j++) begin
            chk("drain_rd", j, 32'(rdq[j].size()), 32'd0);
            chk("drain_st", j, 32'(stq[j].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
